// File: rtl/uart_mmio_responder_pkg.sv
// Shared register map for the UART MMIO window: word offsets, status bit
// positions and a helper that packs a status word.
package uart_mmio_responder_pkg;

    typedef enum logic [1:0] {
        UART_TXRDY  = 2'd0,
        UART_RXVLD  = 2'd1,
        UART_TXDATA = 2'd2,
        UART_RXDATA = 2'd3
    } uart_off_e;

    localparam int UART_ST_RDY_BIT = 0;
    localparam int UART_ST_OVF_BIT = 1;

    function automatic logic [31:0] uart_status(input logic ovf, input logic rdy);
        logic [31:0] w;
        w = '0;
        w[UART_ST_OVF_BIT] = ovf;
        w[UART_ST_RDY_BIT] = rdy;
        return w;
    endfunction

endpackage

// File: rtl/uart_mmio_responder_rx_fifo.sv
// RX byte FIFO: receiver pushes, CPU pops through the RX-data register.
// Pop on empty is ignored; a push while full only lands if a pop frees a slot.
module uart_rx_fifo #(
    parameter int RX_DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic       o_empty,
    output logic       o_full
);
    import uart_mmio_responder_pkg::*;

    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = RX_DEPTH[AW:0];

    logic [7:0]    r_mem [RX_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_MAX);
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers decide what is visible.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// CPU-facing UART register window: TX hold register, RX FIFO, sticky
// overflow flags and a registered 32-bit read-data port.
module uart_mmio_responder #(
    parameter int RX_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [1:0]  i_cpu_addr,
    input  logic        i_cpu_re,
    input  logic        i_cpu_we,
    input  logic [7:0]  i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready
);
    import uart_mmio_responder_pkg::*;

    logic [7:0]  r_hold;
    logic        r_hold_valid;
    logic        r_tx_ovf;
    logic        r_rx_ovf;
    logic [31:0] r_rdata;

    logic        w_xfer;
    logic        w_wr_tx;
    logic        w_load;
    logic        w_tx_ovf_set;
    logic        w_rx_ovf_set;
    logic        w_rd_txrdy;
    logic        w_rd_rxvld;
    logic        w_rd_rxdata;
    logic [7:0]  w_fifo_dout;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic [31:0] w_rdata_nxt;

    assign w_rd_txrdy  = i_cpu_re & (i_cpu_addr == UART_TXRDY);
    assign w_rd_rxvld  = i_cpu_re & (i_cpu_addr == UART_RXVLD);
    assign w_rd_rxdata = i_cpu_re & (i_cpu_addr == UART_RXDATA);

    assign w_xfer       = r_hold_valid & i_tx_ready;
    assign w_wr_tx      = i_cpu_we & (i_cpu_addr == UART_TXDATA);
    assign w_load       = w_wr_tx & (~r_hold_valid | w_xfer);
    assign w_tx_ovf_set = w_wr_tx & r_hold_valid & ~w_xfer;
    // A pop only frees a slot when there is something to pop.
    assign w_rx_ovf_set = i_rx_valid & w_fifo_full & ~(w_rd_rxdata & ~w_fifo_empty);

    uart_rx_fifo #(.RX_DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_rx_valid),
        .i_pop   (w_rd_rxdata),
        .i_din   (i_rx_data),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_comb begin
        w_rdata_nxt = '0;
        case (i_cpu_addr)
            UART_TXRDY:  w_rdata_nxt = uart_status(r_tx_ovf, ~r_hold_valid);
            UART_RXVLD:  w_rdata_nxt = uart_status(r_rx_ovf, ~w_fifo_empty);
            UART_TXDATA: w_rdata_nxt = '0;
            UART_RXDATA: w_rdata_nxt = w_fifo_empty ? 32'd0 : {24'd0, w_fifo_dout};
            default:     w_rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_tx_ovf     <= 1'b0;
            r_rx_ovf     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_load) begin
                r_hold       <= i_cpu_wdata;
                r_hold_valid <= 1'b1;
            end else if (w_xfer) begin
                r_hold_valid <= 1'b0;
            end
            // Set wins over the clearing read in the same cycle.
            r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~w_rd_txrdy);
            r_rx_ovf <= w_rx_ovf_set | (r_rx_ovf & ~w_rd_rxvld);
            if (i_cpu_re) r_rdata <= w_rdata_nxt;
        end
    end

    assign o_cpu_rdata = r_rdata;
    assign o_tx_data   = r_hold;
    assign o_tx_valid  = r_hold_valid;
    assign o_rx_ready  = 1'b1;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed scenarios plus random traffic, checked against a queue-based model.
module tb_uart_mmio_responder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  cpu_addr = '0;
    logic        cpu_re = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    byte unsigned m_q[$];
    logic [7:0]   m_hold = '0;
    logic         m_hv = 1'b0;
    logic         m_tx_ovf = 1'b0;
    logic         m_rx_ovf = 1'b0;
    logic [31:0]  m_rdata = '0;

    always #5 clk = ~clk;

    uart_mmio_responder #(.RX_DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_re    (cpu_re),
        .i_cpu_we    (cpu_we),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_rx_ready  (rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: drive, advance model, compare all outputs just after the edge.
    task automatic cyc(input logic re, input logic we, input logic [1:0] a,
                       input logic [7:0] wd, input logic txr, input logic rxv,
                       input logic [7:0] rxd, input logic rst);
        logic pop, xfer, txset, rxset;
        int   sz;
        cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd; reset = rst;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_hold = 0; m_hv = 0; m_tx_ovf = 0; m_rx_ovf = 0; m_rdata = 0;
        end else begin
            sz = m_q.size();
            if (re) begin
                case (a)
                    2'd0: m_rdata = {30'd0, m_tx_ovf, ~m_hv};
                    2'd1: m_rdata = {30'd0, m_rx_ovf, sz != 0};
                    2'd2: m_rdata = 0;
                    default: m_rdata = (sz != 0) ? {24'd0, m_q[0]} : 32'd0;
                endcase
            end
            pop   = re && a == 2'd3 && sz != 0;
            xfer  = m_hv && txr;
            txset = 0;
            if (we && a == 2'd2) begin
                if (!m_hv || xfer) begin m_hold = wd; m_hv = 1; end
                else txset = 1;
            end else if (xfer) m_hv = 0;
            rxset = 0;
            if (pop) void'(m_q.pop_front());
            if (rxv) begin
                if (sz < DEPTH || pop) m_q.push_back(rxd);
                else rxset = 1;
            end
            m_tx_ovf = txset | (m_tx_ovf & !(re && a == 2'd0));
            m_rx_ovf = rxset | (m_rx_ovf & !(re && a == 2'd1));
        end
        #1;
        reset = 1'b0; cpu_re = 0; cpu_we = 0; rx_valid = 0;
        chk("rdata", cpu_rdata, m_rdata);
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_hv});
        chk("tx_data", {24'd0, tx_data}, {24'd0, m_hold});
        chk("rx_ready", {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1, 0, a, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input logic txr);
        cyc(0, 0, 0, 0, txr, 0, 0, 0);
    endtask

    task automatic push(input logic [7:0] d);
        cyc(0, 0, 0, 0, 0, 1, d, 0);
    endtask

    initial begin
        // 1: reset state
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t1_rst_rdata", cpu_rdata, 0);
        rd(0); chk("t1_off0", cpu_rdata, 1);
        rd(1); chk("t1_off1", cpu_rdata, 0);
        chk("t1_txv", {31'd0, tx_valid}, 0);

        // 2: load hold, transmitter stalled
        cyc(0, 1, 2, 8'h41, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) idle(0);
        chk("t2_txv", {31'd0, tx_valid}, 1);
        chk("t2_txd", {24'd0, tx_data}, 32'h41);
        rd(0); chk("t2_off0", cpu_rdata, 0);

        // 3: overflow the hold, sticky flag cleared by read
        cyc(0, 1, 2, 8'h42, 0, 0, 0, 0);
        rd(0); chk("t3_ovf", cpu_rdata, 2);
        rd(0); chk("t3_clr", cpu_rdata, 0);
        chk("t3_hold", {24'd0, tx_data}, 32'h41);
        idle(1); chk("t3_xfer", {31'd0, tx_valid}, 0);

        // 4: fill, overflow, drain in order, read empty
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
        rd(1); chk("t4_off1", cpu_rdata, 3);
        for (int i = 0; i < 8; i++) begin
            rd(3); chk("t4_pop", cpu_rdata, 32'h10 + i);
        end
        rd(3); chk("t4_empty", cpu_rdata, 0);
        rd(1); chk("t4_off1_e", cpu_rdata, 0);

        // 5: full FIFO, push and pop in the same cycle
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        cyc(1, 0, 3, 0, 0, 1, 8'h99, 0); chk("t5_head", cpu_rdata, 32'h20);
        rd(1); chk("t5_noovf", cpu_rdata, 1);
        for (int i = 1; i < 8; i++) begin
            rd(3); chk("t5_pop", cpu_rdata, 32'h20 + i);
        end
        rd(3); chk("t5_last", cpu_rdata, 32'h99);

        // 6: reset mid-activity, byte in reset cycle discarded
        cyc(0, 1, 2, 8'h55, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
        cyc(0, 0, 0, 0, 0, 1, 8'hEE, 1);
        chk("t6_txv", {31'd0, tx_valid}, 0);
        rd(1); chk("t6_off1", cpu_rdata, 0);
        rd(3); chk("t6_off3", cpu_rdata, 0);

        // empty push+pop: pop returns 0, byte stored
        cyc(1, 0, 3, 0, 0, 1, 8'hA5, 0); chk("pp_empty", cpu_rdata, 0);
        rd(3); chk("pp_stored", cpu_rdata, 32'hA5);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                2'($urandom_range(0, 3)), 8'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4,
                8'($urandom), $urandom_range(0, 299) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
